mem_line_responder: RTL and testbench

Main-memory responder for the direct-mapped cache's miss path. It accepts one line-granular request at a time from the cache controller. For a refill it returns a line of words as a burst after a fixed access latency. For a write-back it absorbs a burst of words, then acknowledges after the same latency. It also keeps read and write service counters that sit alongside the hit/miss counters in the test driver.

---
 rtl/mem_line_responder.sv | 172 +++++++++++++++++
 tb/tb_mem_line_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// Main-memory responder for the cache miss path: line refills are returned as a
// burst after a fixed latency, and write-backs are absorbed then acknowledged.
module mem_line_responder #(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned BW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);
  localparam logic [AW-1:0] OFS_MASK  = AW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] WAIT_INIT = (LATENCY > 0) ? LW'(LATENCY - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    WBURST,
    WAIT,
    RBURST,
    ACK
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic            write_q, write_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [LW-1:0]   wait_q, wait_d;
  logic [31:0]     rd_cnt_q, rd_cnt_d;
  logic [31:0]     wr_cnt_q, wr_cnt_d;

  logic [31:0]     mem_q [MEM_WORDS];
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic            unused_addr_hi;

  // Addresses alias modulo MEM_WORDS; the upper request bits are deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:AW];

  // base is line-aligned, so OR-ing the beat in never carries out of the line.
  assign mem_addr = base_q | AW'(beat_q);

  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      write_q  <= 1'b0;
      beat_q   <= '0;
      wait_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      write_q  <= write_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Backing store has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    write_d   = write_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_data  = '0;
    wr_ack    = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          base_d  = req_addr[AW-1:0] & ~OFS_MASK;
          write_d = req_write;
          beat_d  = '0;
          wait_d  = WAIT_INIT;
          if (req_write) begin
            state_d = WBURST;
          end else if (LATENCY == 0) begin
            state_d = RBURST;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WBURST: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we = 1'b1;
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            wait_d  = WAIT_INIT;
            state_d = (LATENCY == 0) ? ACK : WAIT;
          end
        end
      end

      WAIT: begin
        if (wait_q == '0) begin
          state_d = write_q ? ACK : RBURST;
        end else begin
          wait_d = wait_q - LW'(1);
        end
      end

      RBURST: begin
        rsp_valid = 1'b1;
        rsp_data  = mem_q[mem_addr];
        rsp_last  = (beat_q == LAST_BEAT);
        if (rsp_ready) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            rd_cnt_d = rd_cnt_q + 32'd1;
            state_d  = IDLE;
          end
        end
      end

      ACK: begin
        wr_ack   = 1'b1;
        wr_cnt_d = wr_cnt_q + 32'd1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized self-checking bench for mem_line_responder against a transaction-level
// model of the backing store and the two service counters.
module tb_mem_line_responder;

  localparam int unsigned MW  = 1024;
  localparam int unsigned WPL = 4;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic [31:0] read_count;
  logic [31:0] write_count;

  always #5 clk = ~clk;

  mem_line_responder #(
    .MEM_WORDS     (MW),
    .WORDS_PER_LINE(WPL),
    .LATENCY       (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .read_count (read_count),
    .write_count(write_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mem_m [MW];
  int unsigned known_q [$];
  logic [31:0] rd_m = '0;
  logic [31:0] wr_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned line_of(input logic [31:0] a);
    int unsigned x;
    x = a;
    return (x % MW) & ~(WPL - 1);
  endfunction

  task automatic wait_idle();
    int unsigned w;
    w = 0;
    while (!req_ready && w < 50) begin
      step();
      w++;
    end
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d [WPL]);
    int unsigned ln;
    int unsigned cnt;
    int unsigned gaps;
    logic g;
    ln = line_of(addr);
    req_write = 1'b1;
    req_addr  = addr;
    req_valid = 1'b1;
    wait_idle();
    step();
    // Keep a stray request asserted while busy; it must not be taken.
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    for (int b = 0; b < WPL; b++) begin
      gaps = 0;
      do begin
        check("wr_ready", {31'b0, wr_ready}, 32'd1);
        check("busy_req_ready", {31'b0, req_ready}, 32'd0);
        g = (gaps >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
        wr_valid = g;
        wr_data  = g ? d[b] : $urandom;
        step();
        gaps++;
      end while (!g);
    end
    cnt = 0;
    while (!wr_ack && cnt < LAT + 20) begin
      check("wr_ready_off", {31'b0, wr_ready}, 32'd0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = $urandom;
      step();
      cnt++;
    end
    wr_valid  = 1'b0;
    req_valid = 1'b0;
    check("ack_latency", cnt, LAT);
    check("wc_before_ack", write_count, wr_m);
    for (int b = 0; b < WPL; b++) mem_m[ln + b] = d[b];
    if (!(ln inside {known_q})) known_q.push_back(ln);
    wr_m++;
    step();
    check("ack_pulse", {31'b0, wr_ack}, 32'd0);
    check("write_count", write_count, wr_m);
    check("req_ready_after_wb", {31'b0, req_ready}, 32'd1);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random.
  task automatic do_read(input logic [31:0] addr, input int mode, input int abort_beat);
    int unsigned ln;
    int unsigned cnt;
    int unsigned p;
    int unsigned waits;
    logic r;
    ln = line_of(addr);
    req_write = 1'b0;
    req_addr  = addr;
    req_valid = 1'b1;
    wait_idle();
    step();
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    cnt = 0;
    while (!rsp_valid && cnt < LAT + 20) begin
      check("busy_req_ready", {31'b0, req_ready}, 32'd0);
      step();
      cnt++;
    end
    check("rsp_latency", cnt, LAT);
    p = 0;
    for (int b = 0; b < WPL; b++) begin
      waits = 0;
      do begin
        if (b == abort_beat) begin
          rst_n     = 1'b0;
          rsp_ready = 1'b0;
          req_valid = 1'b0;
          #1;
          check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
          check("rst_rsp_last", {31'b0, rsp_last}, 32'd0);
          check("rst_rsp_data", rsp_data, 32'd0);
          check("rst_req_ready", {31'b0, req_ready}, 32'd0);
          check("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
          check("rst_read_count", read_count, 32'd0);
          check("rst_write_count", write_count, 32'd0);
          rd_m = '0;
          wr_m = '0;
          @(negedge clk);
          rst_n = 1'b1;
          step();
          check("idle_after_rst", {31'b0, req_ready}, 32'd1);
          return;
        end
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_data", rsp_data, mem_m[ln + b]);
        check("rsp_last", {31'b0, rsp_last}, (b == WPL - 1) ? 32'd1 : 32'd0);
        check("busy_req_ready", {31'b0, req_ready}, 32'd0);
        case (mode)
          0:       r = 1'b1;
          1:       r = (p % 3 == 0);
          default: r = (waits >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
        rsp_ready = r;
        if (r && b == WPL - 1) req_valid = 1'b0;
        step();
        p++;
        waits++;
      end while (!r);
    end
    rsp_ready = 1'b0;
    rd_m++;
    check("rsp_valid_off", {31'b0, rsp_valid}, 32'd0);
    check("read_count", read_count, rd_m);
    check("req_ready_after_rd", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d [WPL];
    logic [31:0] a;
    int unsigned k;

    #2;
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_last", {31'b0, rsp_last}, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_wr_ack", {31'b0, wr_ack}, 32'd0);
    check("reset_read_count", read_count, 32'd0);
    check("reset_write_count", write_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Preload 8..11 through a write-back, then refill from mid-line address 0x0A.
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2; d[3] = 32'hA3;
    do_write(32'h8, d);
    do_read(32'h0A, 0, -1);

    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
    do_write(32'h20, d);
    do_read(32'h20, 0, -1);
    do_read(32'h20, 1, -1);

    for (int b = 0; b < WPL; b++) d[b] = $urandom;
    do_write(32'h404, d);
    do_read(32'h004, 2, -1);

    do_read(32'h8, 0, 2);
    do_read(32'h8, 0, -1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1 || known_q.size() == 0) begin
        for (int b = 0; b < WPL; b++) d[b] = $urandom;
        do_write($urandom, d);
      end else begin
        k = $urandom_range(0, known_q.size() - 1);
        a = ($urandom & ~(MW - 1)) | known_q[k] | $urandom_range(0, WPL - 1);
        do_read(a, int'($urandom_range(0, 2)), -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
